// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes rx, samples each bit at its midpoint and
// emits one-cycle rx_ready / frame_error strobes.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : gen_param_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_ready_q, rx_ready_d;
  logic            frame_error_q, frame_error_d;
  logic            rx_meta_q, rx_sync_q;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_ready_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_ready_q    <= rx_ready_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    rx_ready_d    = 1'b0;
    frame_error_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_sync_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A start bit that is high again at its midpoint was a glitch.
          state_d   = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d     = '0;
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            rx_data_d  = shreg_q;
            rx_ready_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_error_d = 1'b1;
            state_d       = StBreak;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_data     = rx_data_q;
  assign rx_ready    = rx_ready_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of frames plus
// hand-written back-to-back, glitch, break and reset sequences.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_error;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge.
  int         ready_total = 0;
  int         ferr_total  = 0;
  int         pulse_viol  = 0;
  int         ready_cyc [64];
  logic [7:0] ready_dat [64];
  int         ferr_cyc  [64];
  logic       prev_ready = 1'b0;
  logic       prev_ferr  = 1'b0;

  always @(negedge clk) begin
    if (rx_ready === 1'b1) begin
      ready_cyc[ready_total % 64] <= cyc;
      ready_dat[ready_total % 64] <= rx_data;
      ready_total <= ready_total + 1;
    end
    if (frame_error === 1'b1) begin
      ferr_cyc[ferr_total % 64] <= cyc;
      ferr_total <= ferr_total + 1;
    end
    if ((rx_ready && frame_error) || (rx_ready && prev_ready) || (frame_error && prev_ferr))
      pulse_viol <= pulse_viol + 1;
    prev_ready <= rx_ready;
    prev_ferr  <= frame_error;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one frame from a falling edge; start returns the index of edge 0.
  // A zero stop bit is left on the line for the caller to release.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int skew,
                            output int start);
    rx    = 1'b0;
    start = cyc + 1;
    repeat (16 + skew) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    if (stop) rx = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stop;
    int         skew;
    int         exp_ready;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int r0, f0, s;
    r0 = ready_total;
    f0 = ferr_total;
    send_frame(v.data, v.stop, v.skew, s);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    check({v.name, " ready count"}, ready_total - r0, v.exp_ready);
    check({v.name, " ferr count"}, ferr_total - f0, v.exp_ferr);
    if (v.exp_ready == 1) begin
      check({v.name, " ready latency"}, ready_cyc[r0 % 64] - s, 154);
      check({v.name, " strobe data"}, ready_dat[r0 % 64], v.exp_data);
    end
    check({v.name, " held rx_data"}, rx_data, v.exp_data);
    check({v.name, " idle busy"}, busy, 1'b0);
  endtask

  vec_t vecs [6];

  initial begin
    int r0, f0, s1, s2;

    vecs[0] = '{"byte00",  8'h00, 1'b1,  0, 1, 0, 8'h00};
    vecs[1] = '{"byte3C",  8'h3C, 1'b1,  0, 1, 0, 8'h3C};
    vecs[2] = '{"byte12",  8'h12, 1'b1,  0, 1, 0, 8'h12};
    vecs[3] = '{"byteA5",  8'hA5, 1'b1,  0, 1, 0, 8'hA5};
    vecs[4] = '{"skew_p3", 8'hC3, 1'b1,  3, 1, 0, 8'hC3};
    vecs[5] = '{"skew_m3", 8'hC3, 1'b1, -3, 1, 0, 8'hC3};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_ready", rx_ready, 1'b0);
    check("reset frame_error", frame_error, 1'b0);
    check("reset busy", busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-to-back frames with no idle between stop and next start.
    r0 = ready_total;
    send_frame(8'h02, 1'b1, 0, s1);
    send_frame(8'h05, 1'b1, 0, s2);
    repeat (24) @(negedge clk);
    check("b2b ready count", ready_total - r0, 2);
    check("b2b first latency", ready_cyc[r0 % 64] - s1, 154);
    check("b2b spacing", ready_cyc[(r0 + 1) % 64] - ready_cyc[r0 % 64], 160);
    check("b2b first data", ready_dat[r0 % 64], 8'h02);
    check("b2b second data", ready_dat[(r0 + 1) % 64], 8'h05);

    // Five-cycle low glitch on an idle line.
    r0 = ready_total;
    f0 = ferr_total;
    rx = 1'b0;
    s1 = cyc + 1;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    check("glitch busy seen", busy, 1'b1);
    repeat (6) @(negedge clk);
    check("glitch busy cycle", cyc - s1, 10);
    check("glitch busy low", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("glitch ready count", ready_total - r0, 0);
    check("glitch ferr count", ferr_total - f0, 0);
    run_vec('{"byte81", 8'h81, 1'b1, 0, 1, 0, 8'h81});

    // Bad stop bit followed by a held-low break.
    r0 = ready_total;
    f0 = ferr_total;
    send_frame(8'h5A, 1'b0, 0, s1);
    repeat (50) @(negedge clk);
    check("break ferr count", ferr_total - f0, 1);
    check("break ferr latency", ferr_cyc[f0 % 64] - s1, 154);
    check("break ready count", ready_total - r0, 0);
    check("break rx_data kept", rx_data, 8'h81);
    check("break busy held", busy, 1'b1);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("break busy released", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("break ferr after", ferr_total - f0, 1);
    check("break ready after", ready_total - r0, 0);

    // Reset in the middle of bit 4 of a 0xFF frame.
    r0 = ready_total;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (72) @(negedge clk);
    check("midreset busy before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset rx_data", rx_data, 8'h00);
    check("midreset rx_ready", rx_ready, 1'b0);
    check("midreset frame_error", frame_error, 1'b0);
    check("midreset busy", busy, 1'b0);
    repeat (100) @(negedge clk);
    check("midreset ready count", ready_total - r0, 0);
    run_vec('{"byte33", 8'h33, 1'b1, 0, 1, 0, 8'h33});

    check("strobe width/exclusive", pulse_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
